// File: rtl/vga_term_writer_pkg.sv
// Shared types and constants for the terminal write controller.
// Character classification lives here so the controller only sees {printable, code}.
package vga_term_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        SCROLL_CLR
    } state_t;

    typedef struct packed {
        logic       printable;
        logic [5:0] code;
    } char_info_t;

    localparam logic [6:0] CR  = 7'h0D;
    localparam logic [6:0] BS  = 7'h08;
    localparam logic [6:0] DEL = 7'h7F;

    localparam logic [5:0] BLANK_CODE_DEFAULT = 6'h20;

    // Lower-case letters and the punctuation above them fold onto the 0x40-0x5E glyphs.
    function automatic char_info_t char_to_code(input logic [6:0] c);
        char_info_t r;
        r.printable = (c >= 7'h20) && (c != DEL);
        if (c >= 7'h60) begin
            r.code = 6'(c - 7'h20);
        end else begin
            r.code = c[5:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_term_writer_if.sv
// Character-in handshake plus VRAM write port of the terminal writer.
// The writer uses the slave view; the character source / testbench uses master.
interface vga_term_writer_if;

    logic        in_valid;
    logic [6:0]  in_char;
    logic        in_ready;
    logic        clr_screen;
    logic        w_en;
    logic [10:0] write_addr;
    logic [5:0]  din;

    modport master (
        output in_valid, in_char, clr_screen,
        input  in_ready, w_en, write_addr, din
    );

    modport slave (
        input  in_valid, in_char, clr_screen,
        output in_ready, w_en, write_addr, din
    );

endinterface

// File: rtl/vga_term_writer.sv
// Terminal write controller: cursor, CR, wrap, clear-screen and hardware scroll into VRAM.
// Optional macro TERM_BACKSPACE_EN adds destructive backspace (0x08) within the current line.
module vga_term_writer
    import vga_term_pkg::*;
#(
    parameter int         COLS       = 40,
    parameter int         ROWS       = 24,
    parameter logic [5:0] BLANK_CODE = BLANK_CODE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    vga_term_writer_if.slave   bus,
    output logic [4:0]         start_row,
    output logic [4:0]         cursor_row,
    output logic [5:0]         cursor_col,
    output logic               busy
);

    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [6:0] COLS_W   = 7'(COLS);
    localparam logic [5:0] ROWS_W   = 6'(ROWS);

    state_t      state_reg, state_next;
    logic [4:0]  clr_row_reg, clr_row_next;
    logic [5:0]  clr_col_reg, clr_col_next;
    logic [4:0]  scroll_row_reg, scroll_row_next;
    logic [4:0]  start_row_reg, start_row_next;
    logic [4:0]  cursor_row_reg, cursor_row_next;
    logic [5:0]  cursor_col_reg, cursor_col_next;
    logic        w_en_reg, w_en_next;
    logic [10:0] write_addr_reg, write_addr_next;
    logic [5:0]  din_reg, din_next;

    logic        in_ready;
    logic        newline;
    char_info_t  info;
    logic [5:0]  row_sum;
    logic [4:0]  phys_row;
    logic [6:0]  col_inc;

    assign info     = char_to_code(bus.in_char);
    assign col_inc  = {1'b0, cursor_col_reg} + 7'd1;

    // Visible rows are rotated by start_row; ROWS need not be a power of two.
    assign row_sum  = {1'b0, cursor_row_reg} + {1'b0, start_row_reg};
    assign phys_row = (row_sum >= ROWS_W) ? 5'(row_sum - ROWS_W) : row_sum[4:0];

    always_comb begin
        state_next      = state_reg;
        clr_row_next    = clr_row_reg;
        clr_col_next    = clr_col_reg;
        scroll_row_next = scroll_row_reg;
        start_row_next  = start_row_reg;
        cursor_row_next = cursor_row_reg;
        cursor_col_next = cursor_col_reg;
        w_en_next       = 1'b0;
        write_addr_next = write_addr_reg;
        din_next        = din_reg;
        in_ready        = 1'b0;
        newline         = 1'b0;

        case (state_reg)
            CLEAR: begin
                w_en_next       = 1'b1;
                write_addr_next = {clr_row_reg, clr_col_reg};
                din_next        = BLANK_CODE;
                if (clr_col_reg == LAST_COL) begin
                    clr_col_next = '0;
                    if (clr_row_reg == LAST_ROW) begin
                        clr_row_next    = '0;
                        start_row_next  = '0;
                        cursor_row_next = '0;
                        cursor_col_next = '0;
                        state_next      = IDLE;
                    end else begin
                        clr_row_next = clr_row_reg + 5'd1;
                    end
                end else begin
                    clr_col_next = clr_col_reg + 6'd1;
                end
            end

            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid && !bus.clr_screen) begin
                    if (bus.in_char == CR) begin
                        newline = 1'b1;
                    end
`ifdef TERM_BACKSPACE_EN
                    else if (bus.in_char == BS) begin
                        if (cursor_col_reg != 6'd0) begin
                            cursor_col_next = cursor_col_reg - 6'd1;
                            w_en_next       = 1'b1;
                            write_addr_next = {phys_row, cursor_col_reg - 6'd1};
                            din_next        = BLANK_CODE;
                        end
                    end
`endif
                    else if (info.printable) begin
                        w_en_next       = 1'b1;
                        write_addr_next = {phys_row, cursor_col_reg};
                        din_next        = info.code;
                        if (col_inc == COLS_W) begin
                            newline = 1'b1;
                        end else begin
                            cursor_col_next = col_inc[5:0];
                        end
                    end

                    // On the bottom line a newline rotates the screen instead of moving the cursor.
                    if (newline) begin
                        cursor_col_next = '0;
                        if (cursor_row_reg != LAST_ROW) begin
                            cursor_row_next = cursor_row_reg + 5'd1;
                        end else begin
                            scroll_row_next = start_row_reg;
                            start_row_next  = (start_row_reg == LAST_ROW) ? 5'd0 : start_row_reg + 5'd1;
                            clr_col_next    = '0;
                            state_next      = SCROLL_CLR;
                        end
                    end
                end
            end

            SCROLL_CLR: begin
                w_en_next       = 1'b1;
                write_addr_next = {scroll_row_reg, clr_col_reg};
                din_next        = BLANK_CODE;
                if (clr_col_reg == LAST_COL) begin
                    clr_col_next = '0;
                    state_next   = IDLE;
                end else begin
                    clr_col_next = clr_col_reg + 6'd1;
                end
            end

            default: begin
                state_next = CLEAR;
            end
        endcase

        // A clear request overrides everything, including a scroll in flight.
        if (bus.clr_screen) begin
            state_next   = CLEAR;
            clr_row_next = '0;
            clr_col_next = '0;
            w_en_next    = 1'b0;
            in_ready     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= CLEAR;
            clr_row_reg    <= '0;
            clr_col_reg    <= '0;
            scroll_row_reg <= '0;
            start_row_reg  <= '0;
            cursor_row_reg <= '0;
            cursor_col_reg <= '0;
            w_en_reg       <= 1'b0;
            write_addr_reg <= '0;
            din_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            clr_row_reg    <= clr_row_next;
            clr_col_reg    <= clr_col_next;
            scroll_row_reg <= scroll_row_next;
            start_row_reg  <= start_row_next;
            cursor_row_reg <= cursor_row_next;
            cursor_col_reg <= cursor_col_next;
            w_en_reg       <= w_en_next;
            write_addr_reg <= write_addr_next;
            din_reg        <= din_next;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.w_en       = w_en_reg;
    assign bus.write_addr = write_addr_reg;
    assign bus.din        = din_reg;
    assign start_row      = start_row_reg;
    assign cursor_row     = cursor_row_reg;
    assign cursor_col     = cursor_col_reg;
    assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_vga_term_writer.sv
// Directed + randomized bench for vga_term_writer against a visible-screen text model.
// Build with TERM_BACKSPACE_EN defined to exercise the backspace path.
module tb_vga_term_writer;

    localparam int COLS = 40;
    localparam int ROWS = 24;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] start_row;
    logic [4:0] cursor_row;
    logic [5:0] cursor_col;
    logic       busy;

    vga_term_writer_if bus ();

    vga_term_writer #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .BLANK_CODE(6'h20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .start_row (start_row),
        .cursor_row(cursor_row),
        .cursor_col(cursor_col),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Everything the DUT writes, plus a shadow of VRAM contents.
    logic [10:0] log_addr [$];
    logic [5:0]  log_din  [$];
    logic [5:0]  tb_vram  [2048];

    always @(posedge clk) begin
        #2;
        if (bus.w_en === 1'b1) begin
            log_addr.push_back(bus.write_addr);
            log_din.push_back(bus.din);
            tb_vram[bus.write_addr] = bus.din;
        end
    end

    // Reference model: the visible text grid, cursor and scroll offset.
    bit [5:0] screen [ROWS][COLS];
    int m_row, m_col, m_start;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                screen[r][c] = 6'h20;
        m_row = 0; m_col = 0; m_start = 0;
    endtask

    task automatic model_char(input logic [6:0] ch, output bit scrolled);
        int ci;
        int code;
        bit nl;
        ci = int'(ch);
        nl = 1'b0;
        scrolled = 1'b0;
        if (ci == 13) begin
            nl = 1'b1;
        end else if (ci == 8) begin
`ifdef TERM_BACKSPACE_EN
            if (m_col > 0) begin
                m_col--;
                screen[m_row][m_col] = 6'h20;
            end
`endif
        end else if (ci >= 32 && ci != 127) begin
            code = (ci >= 96) ? ci - 32 : ci;
            screen[m_row][m_col] = code[5:0];
            m_col++;
            if (m_col == COLS) nl = 1'b1;
        end
        if (nl) begin
            m_col = 0;
            if (m_row < ROWS - 1) begin
                m_row++;
            end else begin
                for (int r = 0; r < ROWS - 1; r++)
                    for (int c = 0; c < COLS; c++)
                        screen[r][c] = screen[r + 1][c];
                for (int c = 0; c < COLS; c++)
                    screen[ROWS - 1][c] = 6'h20;
                m_start = (m_start + 1) % ROWS;
                scrolled = 1'b1;
            end
        end
    endtask

    task automatic wait_idle(input int expected, input string tag);
        int n = 0;
        int ready_bad = 0;
        while (busy === 1'b1 && n < 3000) begin
            if (bus.in_ready !== 1'b0) ready_bad++;
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, n, expected);
        chk({tag, "_ready_low"}, ready_bad, 0);
    endtask

    task automatic send_char(input logic [6:0] ch, input bit do_wait);
        bit scrolled;
        bus.in_valid = 1'b1;
        bus.in_char  = ch;
        #1;
        chk($sformatf("ready_for_%02h", ch), bus.in_ready, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        model_char(ch, scrolled);
        if (scrolled && do_wait) wait_idle(COLS, "scroll");
    endtask

    task automatic do_clear();
        bus.clr_screen = 1'b1;
        @(negedge clk);
        bus.clr_screen = 1'b0;
        model_clear();
        wait_idle(ROWS * COLS, "clear");
    endtask

    task automatic check_screen(input string tag);
        int bad = 0;
        int phys;
        for (int r = 0; r < ROWS; r++) begin
            phys = (r + m_start) % ROWS;
            for (int c = 0; c < COLS; c++)
                if (tb_vram[phys * 64 + c] !== screen[r][c]) bad++;
        end
        chk({tag, "_screen_bad_cells"}, bad, 0);
    endtask

    task automatic check_cursor(input string tag);
        chk({tag, "_cursor_row"}, cursor_row, m_row);
        chk({tag, "_cursor_col"}, cursor_col, m_col);
        chk({tag, "_start_row"}, start_row, m_start);
    endtask

    function automatic logic [6:0] rand_printable();
        return 7'($urandom_range(32, 126));
    endfunction

    initial begin
        int L;
        int bad;
        int sel;
        logic [6:0] ch;

        bus.in_valid = 1'b0;
        bus.in_char = 7'd0;
        bus.clr_screen = 1'b0;

        // Reset and power-up clear
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_w_en", bus.w_en, 1'b0);
        chk("rst_addr", bus.write_addr, 11'd0);
        chk("rst_din", bus.din, 6'd0);
        chk("rst_start_row", start_row, 5'd0);
        chk("rst_cursor_row", cursor_row, 5'd0);
        chk("rst_cursor_col", cursor_col, 6'd0);
        chk("rst_busy", busy, 1'b1);
        rst = 1'b0;
        model_clear();
        wait_idle(ROWS * COLS, "power_clear");
        chk("power_clear_writes", log_addr.size(), ROWS * COLS);
        bad = 0;
        for (int i = 0; i < ROWS * COLS && i < log_addr.size(); i++)
            if (log_addr[i] !== 11'((i / COLS) * 64 + (i % COLS)) || log_din[i] !== 6'h20) bad++;
        chk("power_clear_order", bad, 0);
        chk("power_ready", bus.in_ready, 1'b1);
        check_cursor("power");

        // "A" then "a" back to back
        L = log_addr.size();
        send_char(7'h41, 1'b1);
        send_char(7'h61, 1'b1);
        chk("Aa_writes", log_addr.size(), L + 2);
        chk("A_addr", log_addr[L], 11'd0);
        chk("A_din", log_din[L], 6'h01);
        chk("a_addr", log_addr[L + 1], 11'd1);
        chk("a_din", log_din[L + 1], 6'h01);
        check_cursor("Aa");

        // Line wrap with 41 '*'
        do_clear();
        L = log_addr.size();
        for (int i = 0; i < 41; i++) send_char(7'h2A, 1'b1);
        chk("wrap_writes", log_addr.size(), L + 41);
        chk("wrap_40th_addr", log_addr[L + 39], 11'd39);
        chk("wrap_41st_addr", log_addr[L + 40], {5'd1, 6'd0});
        chk("wrap_41st_din", log_din[L + 40], 6'h2A);
        check_cursor("wrap");
        chk("wrap_model_pos", m_row * 64 + m_col, 65);

        // Scroll from the bottom line
        for (int i = 0; i < ROWS - 2; i++) send_char(7'h0D, 1'b1);
        for (int i = 0; i < 5; i++) send_char(rand_printable(), 1'b1);
        check_cursor("pre_scroll");
        L = log_addr.size();
        send_char(7'h0D, 1'b1);
        check_cursor("post_scroll");
        chk("scroll_start_row", start_row, 5'd1);
        chk("scroll_writes", log_addr.size(), L + COLS);
        bad = 0;
        for (int c = 0; c < COLS && L + c < log_addr.size(); c++)
            if (log_addr[L + c] !== 11'(c) || log_din[L + c] !== 6'h20) bad++;
        chk("scroll_row_blanked", bad, 0);
        send_char(7'h42, 1'b1);
        chk("B_addr", log_addr[log_addr.size() - 1], 11'd0);
        chk("B_din", log_din[log_addr.size() - 1], 6'h02);
        check_screen("after_scroll");

        // Clear request in the middle of a scroll, with a competing character
        send_char(7'h0D, 1'b0);
        repeat (10) @(negedge clk);
        chk("mid_scroll_busy", busy, 1'b1);
        bus.clr_screen = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_char = rand_printable();
        #1;
        chk("clr_blocks_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        bus.clr_screen = 1'b0;
        bus.in_valid = 1'b0;
        model_clear();
        wait_idle(ROWS * COLS, "abort_clear");
        check_cursor("abort_clear");
        check_screen("abort_clear");

        // Ignored control codes
        for (int i = 0; i < 3; i++) send_char(rand_printable(), 1'b1);
        L = log_addr.size();
        send_char(7'h07, 1'b1);
        send_char(7'h7F, 1'b1);
        chk("ctrl_no_write", log_addr.size(), L);
        check_cursor("ctrl");

        // Backspace at (2,3)
        send_char(7'h0D, 1'b1);
        send_char(7'h0D, 1'b1);
        for (int i = 0; i < 3; i++) send_char(rand_printable(), 1'b1);
        L = log_addr.size();
        send_char(7'h08, 1'b1);
`ifdef TERM_BACKSPACE_EN
        chk("bs_writes", log_addr.size(), L + 1);
        chk("bs_addr", log_addr[log_addr.size() - 1], {5'd2, 6'd2});
        chk("bs_din", log_din[log_addr.size() - 1], 6'h20);
        chk("bs_col", cursor_col, 6'd2);
`else
        chk("bs_no_write", log_addr.size(), L);
        chk("bs_col", cursor_col, 6'd3);
`endif
        check_cursor("bs");

        // Randomized traffic with scrolls
        for (int i = 0; i < 1200; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 75) ch = rand_printable();
            else if (sel < 85) ch = 7'h0D;
            else if (sel < 95) ch = 7'($urandom_range(0, 31));
            else ch = (sel < 98) ? 7'h08 : 7'h7F;
            send_char(ch, 1'b1);
            if (i % 300 == 299) begin
                check_cursor($sformatf("rand%0d", i));
                check_screen($sformatf("rand%0d", i));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_term_writer.md
Name: vga_term_writer

Overview:
- Terminal write controller sitting directly upstream of the video RAM (11-bit write address, 6-bit data, active-high w_en).
- Accepts 7-bit ASCII characters from the display PIA path over a valid/ready handshake.
- Maintains the cursor, handles CR, line wrap, clear-screen and hardware scroll.
- Issues one VRAM write per cycle and exports start_row so the VGA read side can rotate rows.

Parameters:
- COLS, 40, visible columns (max 64).
- ROWS, 24, visible rows (max 32).
- BLANK_CODE, 6'h20, 6-bit code written for blank cells.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  character available
- in_char  input  7  ASCII character
- in_ready  output  1  character accepted this cycle when in_valid && in_ready
- clr_screen  input  1  single-cycle pulse requesting full-screen clear
- w_en  output  1  VRAM write strobe
- write_addr  output  11  VRAM write address, {phys_row[4:0], col[5:0]}
- din  output  6  VRAM write data
- start_row  output  5  physical row shown as visible row 0
- cursor_row  output  5  visible cursor row
- cursor_col  output  6  cursor column
- busy  output  1  high in CLEAR or SCROLL_CLR

Behaviour:
- Clocking and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - w_en=0, write_addr=0, din=0
  - start_row=0, cursor_row=0, cursor_col=0
  - state=CLEAR with clear counters at 0, so busy=1 after reset.
- States:
  - CLEAR: one write per cycle of BLANK_CODE, row 0..ROWS-1, col 0..COLS-1, col innermost (960 cycles at defaults). After the last write: start_row=0, cursor=(0,0), go to IDLE.
  - IDLE: in_ready = !clr_screen. When clr_screen=1, go to CLEAR with counters at 0.
  - SCROLL_CLR: write BLANK_CODE to col 0..COLS-1 of physical row scroll_row (40 cycles), then go to IDLE.
- clr_screen in any state restarts CLEAR from (0,0); an in-progress scroll is abandoned. clr_screen has priority over a same-cycle character; that character is not accepted.
- Physical row = (cursor_row + start_row) mod ROWS. No power-of-two wrap.
- Accepted character processing (the write appears on w_en/write_addr/din on the cycle after acceptance; registered outputs):
  - 0x0D (CR): newline, no write.
  - 0x00-0x1F other than CR, and 0x7F: ignored, no write, cursor unchanged.
  - 0x20-0x5F: write code in_char[5:0].
  - 0x60-0x7E: fold to upper case; write (in_char-0x20)[5:0].
  - After each write: cursor_col+1. If the result equals COLS, perform a newline.
- Newline:
  - cursor_row < ROWS-1: cursor_row+1, cursor_col=0. Stay in IDLE.
  - cursor_row == ROWS-1:
    - scroll_row = start_row (old value).
    - start_row = (start_row+1) mod ROWS.
    - cursor_col=0; cursor_row stays ROWS-1.
    - Go to SCROLL_CLR.
- in_ready=0 outside IDLE. Back-to-back characters in IDLE are accepted every cycle.
- w_en is asserted only in the cycle carrying a valid write; at all other times w_en=0 and the address/data values are don't-care.

Optional Feature:
- Macro TERM_BACKSPACE_EN.
- Defined: 0x08 with cursor_col>0 decrements cursor_col and writes BLANK_CODE at the new position. At col 0 it does nothing; no reverse line wrap.
- Undefined: 0x08 is ignored like other control codes.

Decomposition:
- Package vga_term_pkg:
  - state enum (CLEAR, IDLE, SCROLL_CLR)
  - ASCII constants CR=7'h0D, BS=7'h08, DEL=7'h7F
  - BLANK_CODE default
  - a function char_to_code(7-bit) -> {printable, 6-bit code}.
- No sub-module. The char classification is a package function; the FSM, counters and write register are in one module.

Test Plan:
- Reset held 1 cycle, then released -> busy=1 for exactly 960 cycles. Addresses run {0,0}..{23,39} with din=6'h20, then in_ready=1, cursor=(0,0), start_row=0.
- Send "A" (0x41) then "a" (0x61) -> write addr 0 din 6'h01, addr 1 din 6'h01; cursor_col=2.
- Send 41 0x2A characters from (0,0) -> 40 writes on row 0. The 41st goes to addr {1,0}, and cursor=(1,1).
- With cursor=(23,5), start_row=0, send CR -> start_row=1, cursor=(23,0). 40 writes of 6'h20 to physical row 0 with in_ready=0, then in_ready=1. The next "B" is written at phys row 0 ({0,0}).
- In SCROLL_CLR at column 10, pulse clr_screen together with in_valid=1 -> character not accepted; full 960-cycle clear; start_row=0.
- Send 0x07, then 0x7F -> no w_en; cursor unchanged. With TERM_BACKSPACE_EN at cursor (2,3), send 0x08 -> write {2,2} din 6'h20, cursor_col=2.
